// File: rtl/vga_pkg.sv
// Shared definitions for the 640x480@60 VGA timing controller.
// Holds the default raster timing constants, the derived totals and
// active-area start points, and the RGB565 output field layout.
package vga_pkg;

  // Horizontal timing, in pixel clocks
  localparam int unsigned H_SYNC   = 96;
  localparam int unsigned H_BACK   = 48;
  localparam int unsigned H_ACTIVE = 640;
  localparam int unsigned H_FRONT  = 16;

  // Vertical timing, in lines
  localparam int unsigned V_SYNC   = 2;
  localparam int unsigned V_BACK   = 33;
  localparam int unsigned V_ACTIVE = 480;
  localparam int unsigned V_FRONT  = 10;

  localparam int unsigned H_TOTAL  = H_SYNC + H_BACK + H_ACTIVE + H_FRONT;
  localparam int unsigned V_TOTAL  = V_SYNC + V_BACK + V_ACTIVE + V_FRONT;
  localparam int unsigned H_START  = H_SYNC + H_BACK;
  localparam int unsigned V_START  = V_SYNC + V_BACK;

  // Counter / coordinate width
  localparam int unsigned CNT_W    = 10;

  // Colour widths: 10-bit source channels, RGB565 to the DAC
  localparam int unsigned IN_W     = 10;
  localparam int unsigned R_W      = 5;
  localparam int unsigned G_W      = 6;
  localparam int unsigned B_W      = 5;

  typedef struct packed {
    logic [R_W-1:0] r;
    logic [G_W-1:0] g;
    logic [B_W-1:0] b;
  } rgb565_t;

  // Keep the MSBs of each channel; plain truncation, no rounding.
  function automatic rgb565_t to_rgb565(input logic [IN_W-1:0] r,
                                        input logic [IN_W-1:0] g,
                                        input logic [IN_W-1:0] b);
    rgb565_t c;
    c.r = r[IN_W-1 -: R_W];
    c.g = g[IN_W-1 -: G_W];
    c.b = b[IN_W-1 -: B_W];
    return c;
  endfunction

endpackage

// File: rtl/vga_sync_counter.sv
// Raster counters and sync/active decodes.
// Ports:
//   i_clk     pixel clock
//   i_rst_n   asynchronous active-low reset (counters to 0)
//   o_h_cnt   horizontal position, 0..H_TOTAL-1
//   o_v_cnt   vertical position, 0..V_TOTAL-1
//   o_h_sync  horizontal sync, active low
//   o_v_sync  vertical sync, active low
//   o_active  high inside the visible area
module vga_sync_counter #(
  parameter int unsigned H_SYNC   = vga_pkg::H_SYNC,
  parameter int unsigned H_BACK   = vga_pkg::H_BACK,
  parameter int unsigned H_ACTIVE = vga_pkg::H_ACTIVE,
  parameter int unsigned H_FRONT  = vga_pkg::H_FRONT,
  parameter int unsigned V_SYNC   = vga_pkg::V_SYNC,
  parameter int unsigned V_BACK   = vga_pkg::V_BACK,
  parameter int unsigned V_ACTIVE = vga_pkg::V_ACTIVE,
  parameter int unsigned V_FRONT  = vga_pkg::V_FRONT
) (
  input  logic                      i_clk,
  input  logic                      i_rst_n,
  output logic [vga_pkg::CNT_W-1:0] o_h_cnt,
  output logic [vga_pkg::CNT_W-1:0] o_v_cnt,
  output logic                      o_h_sync,
  output logic                      o_v_sync,
  output logic                      o_active
);
  import vga_pkg::*;

  localparam int unsigned H_LAST = H_SYNC + H_BACK + H_ACTIVE + H_FRONT - 1;
  localparam int unsigned V_LAST = V_SYNC + V_BACK + V_ACTIVE + V_FRONT - 1;
  localparam int unsigned H_BEG  = H_SYNC + H_BACK;
  localparam int unsigned H_END  = H_BEG + H_ACTIVE;
  localparam int unsigned V_BEG  = V_SYNC + V_BACK;
  localparam int unsigned V_END  = V_BEG + V_ACTIVE;

  logic [CNT_W-1:0] r_h_cnt;
  logic [CNT_W-1:0] r_v_cnt;
  logic             w_h_wrap;
  logic             w_v_wrap;
  logic             w_h_act;
  logic             w_v_act;

  assign w_h_wrap = (r_h_cnt == CNT_W'(H_LAST));
  assign w_v_wrap = (r_v_cnt == CNT_W'(V_LAST));

  // Vertical counter only moves on the last pixel of a line.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_h_cnt <= '0;
      r_v_cnt <= '0;
    end else begin
      r_h_cnt <= w_h_wrap ? '0 : r_h_cnt + CNT_W'(1);
      if (w_h_wrap) begin
        r_v_cnt <= w_v_wrap ? '0 : r_v_cnt + CNT_W'(1);
      end
    end
  end

  assign w_h_act  = (r_h_cnt >= CNT_W'(H_BEG)) && (r_h_cnt < CNT_W'(H_END));
  assign w_v_act  = (r_v_cnt >= CNT_W'(V_BEG)) && (r_v_cnt < CNT_W'(V_END));

  assign o_h_cnt  = r_h_cnt;
  assign o_v_cnt  = r_v_cnt;
  assign o_h_sync = (r_h_cnt >= CNT_W'(H_SYNC));
  assign o_v_sync = (r_v_cnt >= CNT_W'(V_SYNC));
  assign o_active = w_h_act && w_v_act;

endmodule

// File: rtl/vga_timing_controller.sv
// 640x480@60 VGA timing controller between a pixel source and a VGA DAC.
// Requests pixels by active-area coordinate, takes the 10-bit colour back
// in the same cycle and drives RGB565 plus sync/blank/clock to the DAC.
// Ports:
//   iCLK, iRST_N            pixel clock, asynchronous active-low reset
//   iRed/iGreen/iBlue       10-bit colour for the requested pixel
//   oCoord_X/oCoord_Y       active-area column/row (0 outside active area)
//   oRequest                high while the current pixel is visible
//   oVGA_R/oVGA_G/oVGA_B    RGB565 to the DAC (0 in blanking)
//   oVGA_H_SYNC/oVGA_V_SYNC active-low syncs
//   oVGA_SYNC               composite sync, tied low
//   oVGA_BLANK              DAC blank_n, high only in the active area
//   oVGA_CLOCK              DAC clock, inverted pixel clock
module vga_timing_controller #(
  parameter int unsigned H_SYNC   = vga_pkg::H_SYNC,
  parameter int unsigned H_BACK   = vga_pkg::H_BACK,
  parameter int unsigned H_ACTIVE = vga_pkg::H_ACTIVE,
  parameter int unsigned H_FRONT  = vga_pkg::H_FRONT,
  parameter int unsigned V_SYNC   = vga_pkg::V_SYNC,
  parameter int unsigned V_BACK   = vga_pkg::V_BACK,
  parameter int unsigned V_ACTIVE = vga_pkg::V_ACTIVE,
  parameter int unsigned V_FRONT  = vga_pkg::V_FRONT
) (
  input  logic       iCLK,
  input  logic       iRST_N,
  input  logic [9:0] iRed,
  input  logic [9:0] iGreen,
  input  logic [9:0] iBlue,
  output logic [9:0] oCoord_X,
  output logic [9:0] oCoord_Y,
  output logic       oRequest,
  output logic [4:0] oVGA_R,
  output logic [5:0] oVGA_G,
  output logic [4:0] oVGA_B,
  output logic       oVGA_H_SYNC,
  output logic       oVGA_V_SYNC,
  output logic       oVGA_SYNC,
  output logic       oVGA_BLANK,
  output logic       oVGA_CLOCK
);
  import vga_pkg::*;

  localparam logic [CNT_W-1:0] X_OFS = CNT_W'(H_SYNC + H_BACK);
  localparam logic [CNT_W-1:0] Y_OFS = CNT_W'(V_SYNC + V_BACK);

  logic [CNT_W-1:0] w_h_cnt;
  logic [CNT_W-1:0] w_v_cnt;
  logic             w_active;
  rgb565_t          w_rgb;

  vga_sync_counter #(
    .H_SYNC   (H_SYNC),
    .H_BACK   (H_BACK),
    .H_ACTIVE (H_ACTIVE),
    .H_FRONT  (H_FRONT),
    .V_SYNC   (V_SYNC),
    .V_BACK   (V_BACK),
    .V_ACTIVE (V_ACTIVE),
    .V_FRONT  (V_FRONT)
  ) u_sync (
    .i_clk    (iCLK),
    .i_rst_n  (iRST_N),
    .o_h_cnt  (w_h_cnt),
    .o_v_cnt  (w_v_cnt),
    .o_h_sync (oVGA_H_SYNC),
    .o_v_sync (oVGA_V_SYNC),
    .o_active (w_active)
  );

  assign w_rgb = to_rgb565(iRed, iGreen, iBlue);

  // Coordinates and colour are forced to 0 outside the visible area so the
  // DAC sees black during blanking regardless of what the source returns.
  always_comb begin
    oCoord_X = '0;
    oCoord_Y = '0;
    oVGA_R   = '0;
    oVGA_G   = '0;
    oVGA_B   = '0;
    if (w_active) begin
      oCoord_X = w_h_cnt - X_OFS;
      oCoord_Y = w_v_cnt - Y_OFS;
      oVGA_R   = w_rgb.r;
      oVGA_G   = w_rgb.g;
      oVGA_B   = w_rgb.b;
    end
  end

  assign oRequest   = w_active;
  assign oVGA_BLANK = w_active;
  assign oVGA_SYNC  = 1'b0;
  assign oVGA_CLOCK = ~iCLK;

endmodule

// File: tb/tb_vga_timing_controller.sv
// Self-checking bench for vga_timing_controller. Horizontal timing is the
// 640-pixel default; the vertical active/porch sizes are shrunk so that
// whole frames fit in a short run.
module tb_vga_timing_controller;

  localparam int HS  = 96;
  localparam int HB  = 48;
  localparam int HA  = 640;
  localparam int HF  = 16;
  localparam int VS  = 2;
  localparam int VB  = 3;
  localparam int VA  = 12;
  localparam int VF  = 10;
  localparam int HT  = HS + HB + HA + HF;
  localparam int VT  = VS + VB + VA + VF;
  localparam int HST = HS + HB;
  localparam int VST = VS + VB;
  localparam int FT  = HT * VT;
  localparam int NV  = 8;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [9:0] r_in = '0;
  logic [9:0] g_in = '0;
  logic [9:0] b_in = '0;
  logic [9:0] oCoord_X, oCoord_Y;
  logic       oRequest;
  logic [4:0] oVGA_R, oVGA_B;
  logic [5:0] oVGA_G;
  logic       oVGA_H_SYNC, oVGA_V_SYNC, oVGA_SYNC, oVGA_BLANK, oVGA_CLOCK;

  always #5 clk = ~clk;

  vga_timing_controller #(
    .H_SYNC(HS), .H_BACK(HB), .H_ACTIVE(HA), .H_FRONT(HF),
    .V_SYNC(VS), .V_BACK(VB), .V_ACTIVE(VA), .V_FRONT(VF)
  ) dut (
    .iCLK(clk), .iRST_N(rst_n),
    .iRed(r_in), .iGreen(g_in), .iBlue(b_in),
    .oCoord_X(oCoord_X), .oCoord_Y(oCoord_Y), .oRequest(oRequest),
    .oVGA_R(oVGA_R), .oVGA_G(oVGA_G), .oVGA_B(oVGA_B),
    .oVGA_H_SYNC(oVGA_H_SYNC), .oVGA_V_SYNC(oVGA_V_SYNC),
    .oVGA_SYNC(oVGA_SYNC), .oVGA_BLANK(oVGA_BLANK), .oVGA_CLOCK(oVGA_CLOCK)
  );

  typedef struct {
    logic       hs, vs, req, blank;
    logic [9:0] x, y;
    logic [4:0] r;
    logic [5:0] g;
    logic [4:0] b;
  } exp_t;

  typedef struct {
    logic       act;
    logic [9:0] r, g, b;
    logic [4:0] er;
    logic [5:0] eg;
    logic [4:0] eb;
  } vec_t;

  int   n_cmp = 0;
  int   n_fail = 0;
  exp_t sb_q[$];
  exp_t chk_e;
  vec_t tbl[NV];
  logic tbl_go = 1'b0;
  int   m_h = 0;
  int   m_v = 0;

  logic [39:0] w_dut;
  assign w_dut = {oVGA_H_SYNC, oVGA_V_SYNC, oRequest, oVGA_BLANK,
                  oCoord_X, oCoord_Y, oVGA_R, oVGA_G, oVGA_B};

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference raster position
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_h <= 0;
      m_v <= 0;
    end else if (m_h == HT - 1) begin
      m_h <= 0;
      m_v <= (m_v == VT - 1) ? 0 : m_v + 1;
    end else begin
      m_h <= m_h + 1;
    end
  end

  function automatic exp_t model_out(input int h, input int v,
                                     input logic [9:0] r, input logic [9:0] g,
                                     input logic [9:0] b);
    exp_t e;
    logic a;
    a       = (h >= HST) && (h < HST + HA) && (v >= VST) && (v < VST + VA);
    e.hs    = (h >= HS);
    e.vs    = (v >= VS);
    e.req   = a;
    e.blank = a;
    e.x     = a ? 10'(h - HST) : 10'd0;
    e.y     = a ? 10'(v - VST) : 10'd0;
    e.r     = a ? r[9:5] : 5'd0;
    e.g     = a ? g[9:4] : 6'd0;
    e.b     = a ? b[9:5] : 5'd0;
    return e;
  endfunction

  function automatic logic [39:0] pack_e(input exp_t e);
    return {e.hs, e.vs, e.req, e.blank, e.x, e.y, e.r, e.g, e.b};
  endfunction

  // Scoreboard consumer: one expectation per pixel clock
  always @(negedge clk) begin
    if (sb_q.size() > 0) begin
      chk_e = sb_q.pop_front();
      n_cmp++;
      if (w_dut !== pack_e(chk_e)) begin
        n_fail++;
        $display("FAIL scoreboard: got %h expected %h (h=%0d v=%0d t=%0t)",
                 w_dut, pack_e(chk_e), m_h, m_v, $time);
      end
    end
    check("vga_sync", oVGA_SYNC, 1'b0);
    check("dac_clock_low_phase", oVGA_CLOCK, 1'b1);
  end

  // One stimulus step: drive colour just after the rising edge and queue the
  // expected outputs for the following falling edge.
  task automatic drive_step(input logic use_v, input vec_t v, output logic applied);
    exp_t e;
    @(posedge clk);
    #1;
    check("dac_clock_high_phase", oVGA_CLOCK, 1'b0);
    applied = 1'b0;
    e = model_out(m_h, m_v, '0, '0, '0);
    if (use_v && (e.req == v.act)) begin
      r_in = v.r;
      g_in = v.g;
      b_in = v.b;
      e = model_out(m_h, m_v, r_in, g_in, b_in);
      e.r = v.er;
      e.g = v.eg;
      e.b = v.eb;
      applied = 1'b1;
    end else begin
      r_in = 10'($urandom_range(0, 1023));
      g_in = 10'($urandom_range(0, 1023));
      b_in = 10'($urandom_range(0, 1023));
      e = model_out(m_h, m_v, r_in, g_in, b_in);
    end
    sb_q.push_back(e);
  endtask

  // Colour driver: random colour, then the vector table once tbl_go is set
  initial begin
    vec_t dummy;
    logic ok;
    tbl[0] = '{1'b1, 10'h3FF, 10'h2AA, 10'h155, 5'h1F, 6'h2A, 5'h0A};
    tbl[1] = '{1'b1, 10'h000, 10'h000, 10'h000, 5'h00, 6'h00, 5'h00};
    tbl[2] = '{1'b1, 10'h3FF, 10'h3FF, 10'h3FF, 5'h1F, 6'h3F, 5'h1F};
    tbl[3] = '{1'b1, 10'h01F, 10'h00F, 10'h01F, 5'h00, 6'h00, 5'h00};
    tbl[4] = '{1'b1, 10'h020, 10'h010, 10'h020, 5'h01, 6'h01, 5'h01};
    tbl[5] = '{1'b1, 10'h200, 10'h200, 10'h200, 5'h10, 6'h20, 5'h10};
    tbl[6] = '{1'b1, 10'h1E0, 10'h3F0, 10'h3E0, 5'h0F, 6'h3F, 5'h1F};
    tbl[7] = '{1'b0, 10'h3FF, 10'h2AA, 10'h155, 5'h00, 6'h00, 5'h00};
    dummy = tbl[0];
    while (!tbl_go) drive_step(1'b0, dummy, ok);
    for (int i = 0; i < NV; i++) begin
      ok = 1'b0;
      for (int g = 0; g < FT && !ok; g++) drive_step(1'b1, tbl[i], ok);
      check("table_vector_applied", ok, 1'b1);
    end
    forever drive_step(1'b0, dummy, ok);
  end

  initial begin
    logic p_hs, p_vs, p_req, found;
    int   last_hf, last_vf, hrise, vrise, req_cnt, px, py, fk;

    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n  = 1'b1;
    tbl_go = 1'b1;

    p_hs = 1'b0; p_vs = 1'b0; p_req = 1'b0;
    last_hf = 0; last_vf = 0; hrise = 0; vrise = 0;
    req_cnt = 0; px = 0; py = 0;
    for (int k = 0; k < 2 * FT; k++) begin
      @(negedge clk);
      fk = k % FT;
      if (oVGA_H_SYNC && !p_hs) begin
        check("hsync_low_width", k - last_hf, HS);
        hrise++;
      end
      if (!oVGA_H_SYNC && p_hs) begin
        check("hsync_period", k - last_hf, HT);
        last_hf = k;
      end
      if (oVGA_V_SYNC && !p_vs) begin
        check("vsync_low_width", k - last_vf, VS * HT);
        vrise++;
      end
      if (!oVGA_V_SYNC && p_vs) begin
        check("vsync_period", k - last_vf, FT);
        last_vf = k;
      end
      if (oRequest) begin
        req_cnt++;
        if (req_cnt == 1) begin
          check("first_request_pos", fk, VST * HT + HST);
          check("first_request_x", oCoord_X, 0);
          check("first_request_y", oCoord_Y, 0);
        end
        if (p_req) begin
          check("x_step", oCoord_X, px + 1);
          check("y_hold", oCoord_Y, py);
        end else begin
          check("x_line_start", oCoord_X, 0);
        end
        px = int'(oCoord_X);
        py = int'(oCoord_Y);
      end
      if (fk == FT - 1) begin
        check("requests_per_frame", req_cnt, HA * VA);
        check("last_request_x", px, HA - 1);
        check("last_request_y", py, VA - 1);
        req_cnt = 0;
      end
      p_hs = oVGA_H_SYNC;
      p_vs = oVGA_V_SYNC;
      p_req = oRequest;
    end
    check("hsync_rise_count", hrise, 2 * VT);
    check("vsync_rise_count", vrise, 2);

    // Asynchronous reset in the middle of the active area
    found = 1'b0;
    for (int g = 0; g < FT && !found; g++) begin
      @(posedge clk);
      #1;
      if (m_h == 500 && m_v == 10) found = 1'b1;
    end
    check("reset_point_reached", found, 1'b1);
    check("active_before_reset", oRequest, 1'b1);
    #1;
    rst_n = 1'b0;
    sb_q.delete();
    sb_q.push_back(model_out(0, 0, r_in, g_in, b_in));
    #1;
    check("async_rst_hsync", oVGA_H_SYNC, 1'b0);
    check("async_rst_vsync", oVGA_V_SYNC, 1'b0);
    check("async_rst_request", oRequest, 1'b0);
    check("async_rst_blank", oVGA_BLANK, 1'b0);
    check("async_rst_xy", {oCoord_X, oCoord_Y}, 20'd0);
    check("async_rst_rgb", {oVGA_R, oVGA_G, oVGA_B}, 16'd0);
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;

    p_hs = 1'b0; last_hf = 0; hrise = 0;
    for (int k = 0; k < HT; k++) begin
      @(negedge clk);
      if (oVGA_H_SYNC && !p_hs) begin
        check("restart_hsync_low_width", k - last_hf, HS);
        hrise++;
      end
      p_hs = oVGA_H_SYNC;
    end
    check("restart_hsync_rise_count", hrise, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/vga_timing_controller.md
Name: vga_timing_controller

Overview:
- Generates 640x480@60 VGA raster timing (800x525 total) from one pixel clock.
- Issues a pixel request with active-area X/Y coordinates to the upstream frame source.
- Takes that source's 10-bit-per-channel colour back in the same cycle and drives RGB565 to the DAC, together with sync, blank and clock outputs.
- Sits between the frame buffer/pattern source and the ADV7123-style VGA DAC.

Parameters:
- H_SYNC, 96, horizontal sync pulse width in pixel clocks
- H_BACK, 48, horizontal back porch
- H_ACTIVE, 640, visible pixels per line
- H_FRONT, 16, horizontal front porch
- V_SYNC, 2, vertical sync pulse width in lines
- V_BACK, 33, vertical back porch
- V_ACTIVE, 480, visible lines per frame
- V_FRONT, 10, vertical front porch

Ports:
- iCLK  in  1  pixel clock; one clock domain, rising edge
- iRST_N  in  1  asynchronous active-low reset
- iRed  in  10  red sample for the currently requested pixel
- iGreen  in  10  green sample
- iBlue  in  10  blue sample
- oCoord_X  out  10  active-area column, 0..639
- oCoord_Y  out  10  active-area row, 0..479
- oRequest  out  1  high while the current pixel is in the active area
- oVGA_R  out  5  red, iRed[9:5]
- oVGA_G  out  6  green, iGreen[9:4]
- oVGA_B  out  5  blue, iBlue[9:5]
- oVGA_H_SYNC  out  1  horizontal sync, active low
- oVGA_V_SYNC  out  1  vertical sync, active low
- oVGA_SYNC  out  1  composite sync to DAC, constant 0
- oVGA_BLANK  out  1  DAC blank_n, 1 only in the active area
- oVGA_CLOCK  out  1  DAC clock, equal to ~iCLK

Behaviour:
- Timing totals: H_TOTAL = sum of the H parameters (800); V_TOTAL = sum of the V parameters (525).
- h_cnt: register counting 0..H_TOTAL-1 every clock; wraps to 0.
- v_cnt: register that increments only on the cycle h_cnt == H_TOTAL-1; wraps to 0 after V_TOTAL-1 in that same cycle.
- Reset: asynchronous on iRST_N low; h_cnt = v_cnt = 0. All outputs below are combinational decodes of the counters, so during reset:
  - oVGA_H_SYNC = 0 and oVGA_V_SYNC = 0 (counter 0 lies in the sync pulse);
  - oRequest, oVGA_BLANK, coordinates and RGB are all 0.
- oVGA_H_SYNC = 0 for h_cnt < H_SYNC, else 1.
- oVGA_V_SYNC = 0 for v_cnt < V_SYNC, else 1.
- Active region:
  - H_START = H_SYNC + H_BACK = 144; V_START = V_SYNC + V_BACK = 35.
  - active = (H_START <= h_cnt < H_START + H_ACTIVE) && (V_START <= v_cnt < V_START + V_ACTIVE).
- oRequest = active; oVGA_BLANK = active.
- Coordinates: oCoord_X = h_cnt - H_START and oCoord_Y = v_cnt - V_START when active, else 0.
- Colour: zero latency. Input colour is sampled combinationally in the same cycle as oRequest/coordinates.
  - When active: R/G/B outputs are the truncated MSBs of iRed/iGreen/iBlue (no rounding).
  - When not active: R/G/B outputs are 0.
- oVGA_SYNC tied 0; oVGA_CLOCK = ~iCLK.
- Frame period = 800*525 clocks; line period = 800 clocks.
- Reset released mid-frame: timing restarts from h_cnt = v_cnt = 0, with no partial-line recovery.

Decomposition:
- Shared package vga_pkg holds:
  - the eight timing constants;
  - derived H_TOTAL, V_TOTAL, H_START, V_START;
  - the RGB565 field widths.
- Natural sub-module: vga_sync_counter. It contains the h_cnt/v_cnt registers, wrap logic, sync decodes and the active flag.
- The top level adds coordinate subtraction, colour gating/truncation and the DAC-side constant outputs.

Test Plan:
- Reset held 2 cycles, then released; track the counters:
  - during reset all outputs 0 except oVGA_CLOCK = ~iCLK;
  - first H_SYNC rise at clock 96 after release;
  - first V_SYNC rise at clock 2*800.
- Free-run 2 frames:
  - H_SYNC period 800 clocks, low for 96;
  - V_SYNC period 420000 clocks, low for 1600;
  - exactly 640*480 oRequest cycles per frame.
- Coordinate check:
  - first oRequest at h_cnt=144, v_cnt=35, with X=0, Y=0;
  - last oRequest in a frame shows X=639, Y=479;
  - X steps by 1 each request cycle within a line.
- Colour pass-through: iRed=10'h3FF, iGreen=10'h2AA, iBlue=10'h155:
  - in the active area R=5'h1F, G=6'h2A, B=5'h0A;
  - in blanking all three are 0 and oVGA_BLANK = 0.
- Asynchronous reset asserted at h_cnt=500, v_cnt=200:
  - outputs zero immediately, without waiting for a clock edge;
  - after release, timing restarts from counter 0 (H_SYNC low for 96 clocks).
- oVGA_SYNC stays 0 throughout every scenario.
